uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
- REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 12000000, clk frequency in Hz.
- REQ-003 SHALL derive localparam BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE (clk cycles per bit; 1250 at defaults), integer division, truncated.
- REQ-004 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
- REQ-005 SHALL have port: resetn  input  1  asynchronous, active-low reset.
- REQ-006 SHALL have port: req  input  4  per-requester transmit request, bit i = requester i.
- REQ-007 SHALL have port: data  input  32  requester i byte on data[8*i+7:8*i].
- REQ-008 SHALL have port: grant  output  4  one-hot, high for exactly one cycle when the requester's byte is accepted.
- REQ-009 SHALL have port: busy  output  1  high while a frame is being serialized.
- REQ-010 SHALL have port: cur_id  output  2  index of the requester owning the current or most recent frame.
- REQ-011 SHALL have port: done  output  1  one-cycle pulse at the end of the stop bit.
- REQ-012 SHALL have port: TX  output  1  8N1 serial line, idle high.

Function
- REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
- REQ-014 IDLE: grant SHALL be combinational = one-hot of the round-robin winner when any req is high, else 0; grant SHALL be 0 in every other state.
- REQ-015 On a clk edge in IDLE with any req high: capture the winner's byte into a shift register, set cur_id = winner, set last-grant pointer = winner, go to START.
- REQ-016 Round-robin: search order starts at (pointer+1) mod 4 and wraps; the first set req bit wins; the pointer updates only on a grant.
- REQ-017 Handshake: a requester SHALL hold req and its data stable until it sees grant. The block accepts on the grant cycle. A req still high after grant counts as a new request.
- REQ-018 START: TX = 0 for BIT_PERIOD cycles, then DATA.
- REQ-019 DATA: 8 bits sent LSB first, each for BIT_PERIOD cycles. A 3-bit index counts 0..7, then STOP.
- REQ-020 STOP: TX = 1 for BIT_PERIOD cycles. done = 1 in the final STOP cycle. Next state is IDLE.
- REQ-021 The bit-period counter SHALL be $clog2(BIT_PERIOD)+1 bits wide, count 0..BIT_PERIOD-1, and clear on every bit boundary.
- REQ-022 TX SHALL be registered, with the first start-bit cycle in the cycle after the grant. A frame therefore spans exactly 10*BIT_PERIOD cycles.
- REQ-023 In IDLE, TX SHALL be 1. The minimum gap between back-to-back frames SHALL be one IDLE cycle, in which the grant for the next frame occurs.
- REQ-024 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
- REQ-025 Changes on req or data while busy SHALL NOT affect the frame in flight.
- REQ-026 All 4 req bits high continuously with pointer = 3 SHALL give grant order 0,1,2,3,0,...
- REQ-027 A single persistent requester SHALL be re-granted every frame regardless of the pointer.
- REQ-028 All 4 req bits low in IDLE: the block SHALL stay in IDLE with grant = 0 and the pointer unchanged.

Reset
- REQ-029 resetn low SHALL asynchronously force: state = IDLE, TX = 1, busy = 0, done = 0, cur_id = 0, pointer = 3, shift register = 0, counters = 0.
- REQ-030 Reset asserted mid-frame SHALL abort the frame with no completion: TX goes high immediately and no done pulse is produced.
- REQ-031 After resetn deasserts, the first grant SHALL go to the lowest-index requesting bit.
- REQ-032 While resetn is low, grant SHALL be 0.

Verification (bench uses CLOCK_FREQ_HZ=12000000, BAUD_RATE=1000000, so BIT_PERIOD=12)
- REQ-033 Single frame: req=0001, data[7:0]=8'hA5.
  - Response: grant=0001 for 1 cycle.
  - TX = 0,1,0,1,0,0,1,0,1,1, each level 12 cycles.
  - done pulses at cycle 120 after the grant; cur_id=0.
- REQ-034 Fairness: req=1111 held for 4 frames, bytes 8'h10,8'h21,8'h32,8'h43.
  - Response: grants 0001,0010,0100,1000 in order.
  - Serialized bytes 10,21,32,43; frames spaced 121 cycles grant-to-grant.
- REQ-035 Pointer wrap: grant req=1000, then drive req=1001.
  - Response: next grant=0001 (not 1000).
- REQ-036 Mid-frame data change: grant req=0100 with 8'h3C, then change data to 8'hFF during DATA.
  - Response: 8'h3C is transmitted unchanged; no grant while busy.
- REQ-037 Reset mid-frame: pull resetn low during data bit 3.
  - Response: TX=1 and busy=0 in the same cycle; no done pulse.
  - After release with req=0110: grant=0010.
- REQ-038 Idle: req=0000 for 1000 cycles.
  - Response: TX=1, busy=0, grant=0 and done=0 throughout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter that feeds a single 8N1 UART transmitter.
// One byte is accepted per frame; the line idles high between frames.
module uart_tx_arbiter #(
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic        done,
  output logic        TX
);

  localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(BIT_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          any_req;
  logic          bit_end;

  assign any_req = |req;
  assign bit_end = (cnt == CNT_LAST);

  // Scan from ptr+4 down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    grant = '0;
    if (resetn && state == IDLE && any_req)
      grant = 4'(1) << win;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      TX      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cur_id  <= '0;
      ptr     <= 2'd3;
      shreg   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          TX   <= 1'b1;
          cnt  <= '0;
          if (any_req) begin
            shreg   <= data[8*win +: 8];
            cur_id  <= win;
            ptr     <= win;
            state   <= START;
            TX      <= 1'b0;
            busy    <= 1'b1;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= DATA;
            bit_idx <= '0;
            TX      <= shreg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
              done  <= (BIT_PERIOD == 1);
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TX      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
          end else begin
            cnt  <= cnt + CW'(1);
            done <= (cnt + CW'(1) == CNT_LAST);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level reference
// model (round-robin pick plus expected serial waveform per cycle).
module tb_uart_tx_arbiter;

  localparam int BP  = 12;
  localparam int FRM = 10 * BP;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic        busy;
  logic [1:0]  cur_id;
  logic        done;
  logic        TX;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_ptr = 3;
  int cyc = 0;

  uart_tx_arbiter #(
    .BAUD_RATE(1000000),
    .CLOCK_FREQ_HZ(12000000)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .data(data),
    .grant(grant),
    .busy(busy),
    .cur_id(cur_id),
    .done(done),
    .TX(TX)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  // Applies req/data, waits for a grant and follows the frame cycle by cycle.
  task automatic do_frame(input logic [3:0] r, input logic [31:0] d,
                          input bit scramble, input int abort_at,
                          output int gcyc);
    int w;
    int got;
    logic [7:0] b;
    logic [9:0] bits;
    logic exp_tx;
    logic exp_done;
    req = r;
    data = d;
    got = 0;
    gcyc = -1;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (grant !== 4'b0) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL grant_timeout: grant=%b required a grant for req=%b",
               grant, r);
      return;
    end
    w = rr_pick(r, model_ptr);
    model_ptr = w;
    gcyc = cyc;
    if (grant !== (4'b1 << w))
      $display("FAIL grant_onehot: grant=%b required %b (req=%b)",
               grant, 4'b1 << w, r);
    else pass_cnt++;
    b = d[8*w +: 8];
    bits = {1'b1, b, 1'b0};
    for (int c = 1; c <= FRM; c++) begin
      @(negedge clk);
      exp_tx = bits[(c - 1) / BP];
      exp_done = (c == FRM);
      total_cnt++;
      if (TX !== exp_tx || busy !== 1'b1 || grant !== 4'b0 ||
          done !== exp_done || cur_id !== 2'(w))
        $display({"FAIL frame_cycle %0d: TX=%b busy=%b grant=%b done=%b ",
                  "cur_id=%0d required TX=%b busy=1 grant=0000 done=%b ",
                  "cur_id=%0d byte=%h"}, c, TX, busy, grant, done, cur_id,
                 exp_tx, exp_done, w, b);
      else pass_cnt++;
      if (abort_at > 0 && c == abort_at) return;
      if (scramble && c < FRM) begin
        req = 4'($urandom);
        data = $urandom | 32'h00FF_0000;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req = 4'hF;
    data = $urandom;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        grant !== 4'b0 || cur_id !== 2'd0)
      $display("FAIL reset_state: TX=%b busy=%b done=%b grant=%b cur_id=%0d required 1 0 0 0000 0",
               TX, busy, done, grant, cur_id);
    else pass_cnt++;
    @(negedge clk);
    req = 4'b0;
    resetn = 1'b1;
    model_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_single;
    int g;
    do_frame(4'b0001, 32'h0000_00A5, 1'b0, 0, g);
  endtask

  task automatic test_wrap;
    int g;
    do_frame(4'b1000, $urandom, 1'b0, 0, g);
    do_frame(4'b1001, $urandom, 1'b0, 0, g);
  endtask

  task automatic test_fairness;
    int g;
    int prev;
    do_frame(4'b1000, $urandom, 1'b0, 0, g);
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_frame(4'b1111, 32'h4332_2110, 1'b0, 0, g);
      if (prev >= 0) begin
        total_cnt++;
        if (g - prev !== 121)
          $display("FAIL frame_spacing: got %0d cycles required 121", g - prev);
        else pass_cnt++;
      end
      prev = g;
    end
  endtask

  task automatic test_data_change;
    int g;
    do_frame(4'b0100, 32'h003C_0000, 1'b1, 0, g);
  endtask

  task automatic test_persistent;
    int g;
    for (int i = 0; i < 3; i++)
      do_frame(4'b0010, $urandom, 1'b0, 0, g);
  endtask

  task automatic test_random;
    int g;
    logic [3:0] r;
    for (int i = 0; i < 8; i++) begin
      r = 4'($urandom_range(1, 15));
      do_frame(r, $urandom, 1'b1, 0, g);
    end
  endtask

  task automatic test_idle;
    int g;
    req = 4'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (TX !== 1'b1 || busy !== 1'b0 || grant !== 4'b0 || done !== 1'b0)
        $display("FAIL idle_cycle %0d: TX=%b busy=%b grant=%b done=%b required 1 0 0000 0",
                 i, TX, busy, grant, done);
      else pass_cnt++;
    end
    @(negedge clk);
    do_frame(4'b1111, $urandom, 1'b0, 0, g);
  endtask

  task automatic test_reset_mid;
    int g;
    do_frame(4'b0001, $urandom, 1'b0, 54, g);
    resetn = 1'b0;
    #1;
    total_cnt++;
    if (TX !== 1'b1 || busy !== 1'b0 || grant !== 4'b0)
      $display("FAIL reset_abort: TX=%b busy=%b grant=%b required 1 0 0000",
               TX, busy, grant);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || TX !== 1'b1 || cur_id !== 2'd0)
        $display("FAIL reset_hold: done=%b TX=%b cur_id=%0d required 0 1 0",
                 done, TX, cur_id);
      else pass_cnt++;
    end
    resetn = 1'b1;
    model_ptr = 3;
    do_frame(4'b0110, $urandom, 1'b0, 0, g);
  endtask

  initial begin
    resetn = 1'b0;
    req = 4'b0;
    data = '0;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_data_change();
    test_persistent();
    test_random();
    test_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
